// File: rtl/vpu_llm_phase_sequencer_if.sv
// Issue/response port between the inference self-test sequencer and the VPU.
// The sequencer is the master: it offers operations and absorbs results.
interface vpu_llm_phase_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              issue_valid;
  logic              issue_ready;
  logic [1:0]        issue_op;
  logic [15:0]       issue_idx;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output issue_valid,
    output issue_op,
    output issue_idx,
    input  issue_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  issue_valid,
    input  issue_op,
    input  issue_idx,
    output issue_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/vpu_llm_phase_sequencer.sv
// Runs the GEMV / dot / MAC-stress self-test phases on the VPU, bounds in-flight
// operations, checksums results per phase and reports pass or fail with a cause.
module vpu_llm_phase_sequencer #(
  parameter int                DATA_W          = 32,
  parameter int                GEMV_OPS        = 16,
  parameter int                DOT_OPS         = 8,
  parameter int                STRESS_OPS      = 64,
  parameter int                MAX_OUTSTANDING = 4,
  parameter int                TIMEOUT_CYCLES  = 4096,
  parameter logic [DATA_W-1:0] GOLDEN_GEMV     = '0,
  parameter logic [DATA_W-1:0] GOLDEN_DOT      = '0,
  parameter logic [DATA_W-1:0] GOLDEN_STRESS   = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  vpu_llm_phase_sequencer_if.master        vpu,
  output logic                             busy,
  output logic                             done,
  output logic                             pass,
  output logic                             fail,
  output logic [1:0]                       fail_phase,
  output logic [1:0]                       fail_code,
  output logic [31:0]                      total_ops,
  output logic [2:0]                       state_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_CHECK = 3'd2,
    ST_PASS  = 3'd3,
    ST_FAIL  = 3'd4
  } state_t;

  localparam int               OUT_W       = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] OUT_MAX     = OUT_W'(MAX_OUTSTANDING);
  // Watchdog trips on the edge where it would reach TIMEOUT_CYCLES-1.
  localparam int               WD_LAST_INT = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 2 : 0;
  localparam logic [31:0]      WD_LAST     = 32'(WD_LAST_INT);

  localparam logic [1:0] FC_MISMATCH = 2'd0;
  localparam logic [1:0] FC_TIMEOUT  = 2'd1;
  localparam logic [1:0] FC_SPURIOUS = 2'd2;

  state_t            state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic [15:0]       issued_q, issued_d;
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [31:0]       watchdog_q, watchdog_d;
  logic [31:0]       total_ops_q, total_ops_d;
  logic [1:0]        fail_phase_q, fail_phase_d;
  logic [1:0]        fail_code_q, fail_code_d;

  logic [15:0]       phase_len;
  logic [DATA_W-1:0] phase_golden;
  logic              issue_valid_w;
  logic              handshake;
  logic              rsp_w;

  always_comb begin
    phase_len    = '0;
    phase_golden = '0;
    case (phase_q)
      2'd0: begin
        phase_len    = 16'(GEMV_OPS);
        phase_golden = GOLDEN_GEMV;
      end
      2'd1: begin
        phase_len    = 16'(DOT_OPS);
        phase_golden = GOLDEN_DOT;
      end
      2'd2: begin
        phase_len    = 16'(STRESS_OPS);
        phase_golden = GOLDEN_STRESS;
      end
      default: begin
        phase_len    = '0;
        phase_golden = '0;
      end
    endcase
  end

  // Offer is decoded from registers only so issue_ready never loops back.
  assign issue_valid_w = (state_q == ST_RUN) && (issued_q < phase_len) &&
                         (outstanding_q < OUT_MAX);
  assign handshake     = issue_valid_w && vpu.issue_ready;
  assign rsp_w         = vpu.rsp_valid;

  assign vpu.issue_valid = issue_valid_w;
  assign vpu.issue_op    = phase_q;
  assign vpu.issue_idx   = issued_q;

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    issued_d      = issued_q;
    outstanding_d = outstanding_q;
    acc_d         = acc_q;
    watchdog_d    = watchdog_q;
    total_ops_d   = total_ops_q;
    fail_phase_d  = fail_phase_q;
    fail_code_d   = fail_code_q;

    case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (start) begin
          state_d       = ST_RUN;
          phase_d       = '0;
          issued_d      = '0;
          outstanding_d = '0;
          acc_d         = '0;
          watchdog_d    = '0;
          total_ops_d   = '0;
          fail_phase_d  = '0;
          fail_code_d   = '0;
        end
      end

      ST_RUN: begin
        if (rsp_w && (outstanding_q == '0)) begin
          state_d      = ST_FAIL;
          fail_phase_d = phase_q;
          fail_code_d  = FC_SPURIOUS;
        end else if ((issued_q == phase_len) && (outstanding_q == '0)) begin
          state_d = ST_CHECK;
        end else begin
          if (handshake) begin
            issued_d = issued_q + 16'd1;
          end
          if (rsp_w) begin
            acc_d       = acc_q + vpu.rsp_data;
            total_ops_d = total_ops_q + 32'd1;
          end
          case ({handshake, rsp_w})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
          endcase
          if (handshake || rsp_w) begin
            watchdog_d = '0;
          end else if (watchdog_q == WD_LAST) begin
            state_d      = ST_FAIL;
            fail_phase_d = phase_q;
            fail_code_d  = FC_TIMEOUT;
          end else begin
            watchdog_d = watchdog_q + 32'd1;
          end
        end
      end

      ST_CHECK: begin
        if (acc_q != phase_golden) begin
          state_d      = ST_FAIL;
          fail_phase_d = phase_q;
          fail_code_d  = FC_MISMATCH;
        end else if (phase_q == 2'd2) begin
          state_d = ST_PASS;
        end else begin
          state_d    = ST_RUN;
          phase_d    = phase_q + 2'd1;
          issued_d   = '0;
          acc_d      = '0;
          watchdog_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      phase_q       <= '0;
      issued_q      <= '0;
      outstanding_q <= '0;
      acc_q         <= '0;
      watchdog_q    <= '0;
      total_ops_q   <= '0;
      fail_phase_q  <= '0;
      fail_code_q   <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      issued_q      <= issued_d;
      outstanding_q <= outstanding_d;
      acc_q         <= acc_d;
      watchdog_q    <= watchdog_d;
      total_ops_q   <= total_ops_d;
      fail_phase_q  <= fail_phase_d;
      fail_code_q   <= fail_code_d;
    end
  end

  assign busy       = (state_q == ST_RUN) || (state_q == ST_CHECK);
  assign done       = (state_q == ST_PASS) || (state_q == ST_FAIL);
  assign pass       = (state_q == ST_PASS);
  assign fail       = (state_q == ST_FAIL);
  assign fail_phase = fail_phase_q;
  assign fail_code  = fail_code_q;
  assign total_ops  = total_ops_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_vpu_llm_phase_sequencer.sv
// Directed scenarios with a randomized VPU responder; expectations come from a
// transaction-level model of issued ops, delivered results and phase checksums.
module tb_vpu_llm_phase_sequencer;

  localparam int          DATA_W = 32;
  localparam int          N0     = 16;
  localparam int          N1     = 8;
  localparam int          N2     = 64;
  localparam int          MAXO   = 4;
  localparam int          TMO    = 4096;
  localparam logic [31:0] G0     = 32'd136;
  localparam logic [31:0] G1     = 32'd36;
  localparam logic [31:0] G2     = 32'd2080;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_PASS = 3'd3;
  localparam logic [2:0] S_FAIL = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass, fail;
  logic [1:0]  fail_phase, fail_code;
  logic [31:0] total_ops;
  logic [2:0]  state_o;

  vpu_llm_phase_sequencer_if #(.DATA_W(DATA_W)) vif ();

  vpu_llm_phase_sequencer #(
    .DATA_W(DATA_W), .GEMV_OPS(N0), .DOT_OPS(N1), .STRESS_OPS(N2),
    .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TMO),
    .GOLDEN_GEMV(G0), .GOLDEN_DOT(G1), .GOLDEN_STRESS(G2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vpu(vif),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .fail_phase(fail_phase), .fail_code(fail_code),
    .total_ops(total_ops), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Responder and scoreboard state
  typedef struct {
    int unsigned due;
    logic [1:0]  op;
    logic [15:0] idx;
  } pend_t;

  pend_t       pq[$];
  int          ready_pct = 100;
  int          lat_min = 3;
  int          lat_max = 3;
  bit          run_live, drop_arm, dropped, corrupt_arm, spur_arm, spur_fired;
  int          hs_cnt[3];
  logic [31:0] sum[3];
  logic [31:0] gold[3];
  int          delivered, hs_total, last_op;
  int unsigned last_act;

  task automatic clear_model();
    for (int p = 0; p < 3; p++) begin
      hs_cnt[p] = 0;
      sum[p]    = '0;
    end
    delivered   = 0;
    hs_total    = 0;
    last_op     = 0;
    last_act    = 0;
    drop_arm    = 0;
    dropped     = 0;
    corrupt_arm = 0;
    spur_arm    = 0;
    spur_fired  = 0;
  endtask

  // VPU model: drives ready/responses on the falling edge, records handshakes.
  initial begin : responder
    pend_t       p;
    logic        rdy;
    logic [31:0] data;
    bit          prev_stall;
    logic [1:0]  prev_op;
    logic [15:0] prev_idx;
    int          cur_out;
    prev_stall = 0;
    prev_op = '0;
    prev_idx = '0;
    vif.issue_ready = 1'b0;
    vif.rsp_valid = 1'b0;
    vif.rsp_data = '0;
    forever begin
      @(negedge clk);
      vif.rsp_valid = 1'b0;
      vif.rsp_data  = '0;
      rdy = rst_n && ($urandom_range(99) < 32'(ready_pct));
      cur_out = hs_total - delivered;

      if (prev_stall && rst_n && state_o == S_RUN) begin
        check("stall_valid_held", 32'(vif.issue_valid), 32'd1);
        check("stall_op_held", 32'(vif.issue_op), 32'(prev_op));
        check("stall_idx_held", 32'(vif.issue_idx), 32'(prev_idx));
      end
      if (run_live && state_o == S_RUN && cur_out >= MAXO)
        check("valid_low_at_limit", 32'(vif.issue_valid), 32'd0);

      if (spur_arm && rst_n && hs_cnt[2] > 0 && cur_out == 0 && state_o == S_RUN) begin
        vif.rsp_valid = 1'b1;
        vif.rsp_data  = $urandom;
        rdy        = 1'b0;
        spur_arm   = 0;
        spur_fired = 1;
        last_act   = cyc;
      end else if (pq.size() > 0 && pq[0].due <= cyc) begin
        p = pq.pop_front();
        if (drop_arm && p.op == 2'd0 && p.idx == 16'd5) begin
          drop_arm = 0;
          dropped  = 1;
        end else begin
          data = 32'(p.idx) + 32'd1 +
                 ((corrupt_arm && p.op == 2'd1 && p.idx == 16'd0) ? 32'd1 : 32'd0);
          vif.rsp_valid = 1'b1;
          vif.rsp_data  = data;
          if (run_live) begin
            delivered++;
            sum[p.op] = sum[p.op] + data;
            last_act  = cyc;
          end
        end
      end

      vif.issue_ready = rdy;
      if (vif.issue_valid && rdy) begin
        check("issue_op_range", 32'(vif.issue_op <= 2'd2), 32'd1);
        if (vif.issue_op <= 2'd2) begin
          check("issue_idx_order", 32'(vif.issue_idx), 32'(hs_cnt[vif.issue_op]));
          hs_cnt[vif.issue_op]++;
        end
        hs_total++;
        check("outstanding_bound", 32'((hs_total - delivered) <= MAXO), 32'd1);
        pq.push_back('{cyc + $urandom_range(lat_max, lat_min), vif.issue_op, vif.issue_idx});
        last_op  = int'(vif.issue_op);
        last_act = cyc;
      end
      prev_stall = vif.issue_valid && !rdy;
      prev_op    = vif.issue_op;
      prev_idx   = vif.issue_idx;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/state"}, 32'(state_o), 32'(S_IDLE));
    check({tag, "/busy"}, 32'(busy), 32'd0);
    check({tag, "/done"}, 32'(done), 32'd0);
    check({tag, "/pass"}, 32'(pass), 32'd0);
    check({tag, "/fail"}, 32'(fail), 32'd0);
    check({tag, "/fail_phase"}, 32'(fail_phase), 32'd0);
    check({tag, "/fail_code"}, 32'(fail_code), 32'd0);
    check({tag, "/total_ops"}, total_ops, 32'd0);
    check({tag, "/issue_valid"}, 32'(vif.issue_valid), 32'd0);
  endtask

  task automatic launch(input string tag, input int rp, input int lmin, input int lmax);
    for (int i = 0; i < 200 && pq.size() != 0; i++) tick();
    check({tag, "/queue_drained"}, 32'(pq.size()), 32'd0);
    ready_pct = rp;
    lat_min   = lmin;
    lat_max   = lmax;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_live = 1;
    check({tag, "/run_state"}, 32'(state_o), 32'(S_RUN));
    check({tag, "/first_valid"}, 32'(vif.issue_valid), 32'd1);
    check({tag, "/first_idx"}, 32'(vif.issue_idx), 32'd0);
    check({tag, "/first_op"}, 32'(vif.issue_op), 32'd0);
    check({tag, "/total_cleared"}, total_ops, 32'd0);
    check({tag, "/busy"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_end(input string tag, input int budget, output int unsigned end_cyc);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    if (!done) check({tag, "/end_within_budget"}, 32'(done), 32'd1);
    run_live = 0;
    end_cyc  = cyc;
  endtask

  task automatic verify_verdict(input string tag);
    logic [2:0] es;
    logic [1:0] ep, ec;
    es = S_PASS;
    ep = 2'd0;
    ec = 2'd0;
    if (spur_fired) begin
      es = S_FAIL; ep = 2'(last_op); ec = 2'd2;
    end else if (dropped) begin
      es = S_FAIL; ep = 2'(last_op); ec = 2'd1;
    end else begin
      for (int p = 0; p < 3; p++)
        if (es == S_PASS && sum[p] != gold[p]) begin
          es = S_FAIL; ep = 2'(p); ec = 2'd0;
        end
    end
    check({tag, "/state"}, 32'(state_o), 32'(es));
    check({tag, "/done"}, 32'(done), 32'd1);
    check({tag, "/pass"}, 32'(pass), 32'(es == S_PASS));
    check({tag, "/fail"}, 32'(fail), 32'(es == S_FAIL));
    check({tag, "/busy"}, 32'(busy), 32'd0);
    check({tag, "/fail_phase"}, 32'(fail_phase), 32'(ep));
    check({tag, "/fail_code"}, 32'(fail_code), 32'(ec));
    check({tag, "/total_ops"}, total_ops, 32'(delivered));
    check({tag, "/valid_idle"}, 32'(vif.issue_valid), 32'd0);
    if (es == S_PASS) begin
      check({tag, "/gemv_issued"}, 32'(hs_cnt[0]), 32'(N0));
      check({tag, "/dot_issued"}, 32'(hs_cnt[1]), 32'(N1));
      check({tag, "/stress_issued"}, 32'(hs_cnt[2]), 32'(N2));
    end
  endtask

  initial begin : stimulus
    int unsigned end_cyc;
    int          n;
    gold[0] = G0;
    gold[1] = G1;
    gold[2] = G2;
    clear_model();
    run_live = 0;

    rst_n = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Nominal: fixed latency 3, always ready
    clear_model();
    launch("nominal", 100, 3, 3);
    wait_end("nominal", 3000, end_cyc);
    verify_verdict("nominal");
    check("nominal/total_88", total_ops, 32'd88);

    // Backpressure: ready low ~30% of cycles, latency 1..10
    clear_model();
    launch("backpressure", 70, 1, 10);
    wait_end("backpressure", 6000, end_cyc);
    verify_verdict("backpressure");
    check("backpressure/total_88", total_ops, 32'd88);

    // Dot checksum off by one
    clear_model();
    corrupt_arm = 1;
    launch("mismatch", 100, 1, 4);
    wait_end("mismatch", 3000, end_cyc);
    verify_verdict("mismatch");
    check("mismatch/fail_phase_dot", 32'(fail_phase), 32'd1);
    check("mismatch/total_24", total_ops, 32'd24);
    check("mismatch/no_stress_issue", 32'(hs_cnt[2]), 32'd0);

    // Lost GEMV response 5
    clear_model();
    drop_arm = 1;
    launch("timeout", 80, 1, 6);
    wait_end("timeout", 8000, end_cyc);
    verify_verdict("timeout");
    check("timeout/code", 32'(fail_code), 32'd1);
    check("timeout/delay", end_cyc - (last_act + 1), 32'(TMO - 1));

    // Unsolicited response during stress phase
    clear_model();
    spur_arm = 1;
    launch("spurious", 80, 1, 6);
    wait_end("spurious", 6000, end_cyc);
    verify_verdict("spurious");
    check("spurious/phase", 32'(fail_phase), 32'd2);
    check("spurious/code", 32'(fail_code), 32'd2);

    // Reset in the middle of the dot phase, stray responses afterwards
    clear_model();
    launch("midreset", 80, 1, 6);
    n = 0;
    while (hs_cnt[1] < 3 && n < 1000) begin
      tick();
      n++;
    end
    check("midreset/reached_dot", 32'(hs_cnt[1] >= 3), 32'd1);
    rst_n = 1'b0;
    run_live = 0;
    tick();
    check_all_zero("midreset");
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    check("midreset/stray_state", 32'(state_o), 32'(S_IDLE));
    check("midreset/stray_total", total_ops, 32'd0);

    clear_model();
    launch("restart1", 100, 3, 3);
    wait_end("restart1", 3000, end_cyc);
    verify_verdict("restart1");
    check("restart1/total_88", total_ops, 32'd88);

    clear_model();
    launch("restart2", 100, 3, 3);
    wait_end("restart2", 3000, end_cyc);
    verify_verdict("restart2");
    check("restart2/total_88", total_ops, 32'd88);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
